// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, programmable wait latency,
// response held on a valid/ready channel until the initiator consumes it.
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  generate
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $error("data_mem_responder: LATENCY must be within 0..15");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("data_mem_responder: DEPTH_WORDS must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_next_cnt;
  logic        r_rst_done;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_commit;
  logic          w_cmt_write;
  logic [31:0]   w_cmt_addr;
  logic [31:0]   w_cmt_wdata;
  logic [AW-1:0] w_idx;
  logic          w_err;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // req_ready is high only in IDLE once reset has been seen released by a clock edge;
  // resp_valid is high only in RESP and the response holds until resp_ready is sampled.
  assign req_ready  = (r_state == ST_IDLE) && r_rst_done;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign dbg_state  = r_state;
  assign w_accept   = req_valid && req_ready;

  // With zero latency the commit edge is the accept edge, so the live request is used.
  assign w_cmt_write = (r_state == ST_IDLE) ? req_write : r_write;
  assign w_cmt_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_cmt_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
  assign w_idx       = w_cmt_addr[AW+1:2];
  assign w_err       = (w_cmt_addr[1:0] != 2'b00) || ((w_cmt_addr >> (AW + 2)) != 32'd0);
  assign w_commit    = (r_state != ST_RESP) && (w_next_state == ST_RESP);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 0) begin
            w_next_state = ST_RESP;
          end else begin
            w_next_state = ST_WAIT;
            w_next_cnt   = LAT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_rst_done <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_rst_done <= 1'b1;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (!w_cmt_write && !w_err) ? r_mem[w_idx] : 32'd0;
      end else if ((r_state == ST_RESP) && resp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  // Storage is deliberately not reset; an aborted store never reaches its commit edge.
  always_ff @(posedge clk) begin
    if (w_commit && w_cmt_write && !w_err) begin
      r_mem[w_idx] <= w_cmt_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=0 instance driven by directed
// steps and random accesses, checked against a word-array model of the memory.
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_rdata [2];
  logic [1:0]  resp_err;
  logic [1:0]  dbg_state [2];

  int          n_vec = 0;
  int          n_err = 0;
  int          lat [2] = '{LAT_A, LAT_B};
  logic [31:0] m_mem [2][DEPTH];
  bit          m_vld [2][DEPTH];
  logic [31:0] exp_rd;
  logic        exp_err;
  bit          exp_chk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .dbg_state(dbg_state[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .dbg_state(dbg_state[1])
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: expectation from the address rules, before the access is applied.
  task automatic predict(input int d, input bit wr, input logic [31:0] addr);
    int idx;
    exp_err = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
    idx     = exp_err ? 0 : int'(addr / 4);
    exp_chk = 1'b1;
    exp_rd  = 32'd0;
    if (!wr && !exp_err) begin
      exp_chk = m_vld[d][idx];
      exp_rd  = m_mem[d][idx];
    end
  endtask

  task automatic commit_model(input int d, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata);
    if (wr && (addr % 4 == 0) && ((addr / 4) < DEPTH)) begin
      m_mem[d][addr / 4] = wdata;
      m_vld[d][addr / 4] = 1'b1;
    end
  endtask

  // Driver tasks
  task automatic start_req(input int d, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int waited = 0;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    while (req_ready[d] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", 32'(waited < 20), 32'd1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom();
    req_wdata[d] = $urandom();
  endtask

  task automatic wait_resp(input int d);
    int cycles = 1;
    while (resp_valid[d] !== 1'b1 && cycles < 40) begin
      check("busy_ready", 32'(req_ready[d]), 32'd0);
      @(posedge clk);
      #1;
      cycles++;
    end
    check("resp_latency", 32'(cycles), 32'(lat[d] + 1));
  endtask

  task automatic check_resp(input int d, input string tag);
    check({tag, "_valid"}, 32'(resp_valid[d]), 32'd1);
    check({tag, "_err"}, 32'(resp_err[d]), 32'(exp_err));
    check({tag, "_busy"}, 32'(req_ready[d]), 32'd0);
    if (exp_chk) check({tag, "_rdata"}, resp_rdata[d], exp_rd);
  endtask

  task automatic finish_resp(input int d);
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    check("done_valid", 32'(resp_valid[d]), 32'd0);
    check("done_rdata", resp_rdata[d], 32'd0);
    check("done_err", 32'(resp_err[d]), 32'd0);
    check("done_ready", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic do_access(input int d, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold);
    predict(d, wr, addr);
    start_req(d, wr, addr, wdata);
    commit_model(d, wr, addr, wdata);
    wait_resp(d);
    check_resp(d, "resp");
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_resp(d, "hold");
    end
    finish_resp(d);
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ready_a", 32'(req_ready[0]), 32'd0);
    check("rst_valid_a", 32'(resp_valid[0]), 32'd0);
    check("rst_rdata_a", resp_rdata[0], 32'd0);
    check("rst_err_a", 32'(resp_err[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready_low", 32'(req_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    check("rel_ready_high", 32'(req_ready[0]), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    bit          wr;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_write  = '0;
    resp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      req_addr[d]  = '0;
      req_wdata[d] = '0;
    end

    // Reset state
    #12;
    check("init_ready_a", 32'(req_ready[0]), 32'd0);
    check("init_ready_b", 32'(req_ready[1]), 32'd0);
    check("init_valid_a", 32'(resp_valid[0]), 32'd0);
    check("init_rdata_a", resp_rdata[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready_a", 32'(req_ready[0]), 32'd1);
    check("rel_ready_b", 32'(req_ready[1]), 32'd1);

    // Store then load, then backpressure on a load
    do_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    do_access(0, 1'b0, 32'h10, 32'h0, 0);
    do_access(0, 1'b0, 32'h10, 32'h0, 5);

    // Error accesses leave the stored word untouched
    do_access(0, 1'b1, 32'h12, 32'h55AA55AA, 0);
    do_access(0, 1'b0, 32'h400, 32'h0, 1);
    do_access(0, 1'b1, 32'h8000_0010, 32'h11111111, 0);
    do_access(0, 1'b0, 32'h10, 32'h0, 0);
    do_access(0, 1'b0, 32'h3FC, 32'h0, 0);

    // Zero-latency instance: back-to-back loads, one response every two cycles
    do_access(1, 1'b1, 32'h0, 32'hA0A0_0000, 0);
    do_access(1, 1'b1, 32'h4, 32'hB0B0_0004, 0);
    @(negedge clk);
    req_valid[1]  = 1'b1;
    req_write[1]  = 1'b0;
    req_addr[1]   = 32'h0;
    resp_ready[1] = 1'b1;
    check("b2b_ready0", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    #1;
    req_addr[1] = 32'h4;
    check("b2b_valid0", 32'(resp_valid[1]), 32'd1);
    check("b2b_rdata0", resp_rdata[1], m_mem[1][0]);
    @(posedge clk);
    #1;
    check("b2b_gap", 32'(resp_valid[1]), 32'd0);
    check("b2b_ready1", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    check("b2b_valid1", 32'(resp_valid[1]), 32'd1);
    check("b2b_rdata1", resp_rdata[1], m_mem[1][1]);
    @(posedge clk);
    #1;
    resp_ready[1] = 1'b0;
    check("b2b_idle", 32'(resp_valid[1]), 32'd0);

    // Reset while a store waits: store is discarded
    do_access(0, 1'b1, 32'h20, 32'hCAFEF00D, 0);
    start_req(0, 1'b1, 32'h20, 32'h0000_1234);
    pulse_reset();
    do_access(0, 1'b0, 32'h20, 32'h0, 0);

    // Reset while a store is already responding: store stays committed
    predict(0, 1'b1, 32'h30);
    start_req(0, 1'b1, 32'h30, 32'h600D_D00D);
    commit_model(0, 1'b1, 32'h30, 32'h600D_D00D);
    wait_resp(0);
    pulse_reset();
    do_access(0, 1'b0, 32'h30, 32'h0, 0);

    // Random traffic on both instances
    for (int n = 0; n < 120; n++) begin
      wr = 1'($urandom_range(0, 1));
      w  = $urandom();
      case ($urandom_range(0, 9))
        0:       a = {$urandom_range(0, 63), 2'b00} | 32'($urandom_range(1, 3));
        1:       a = 32'(DEPTH * 4) + ($urandom() & 32'h00FF_FFFC);
        default: a = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
      endcase
      do_access(n % 2, wr, a, w, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
